// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: opcodes, bubble word,
// fetch FSM state encoding and the J-type target helper.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OP_J      = 6'b000010;
    localparam logic [5:0]  OP_BEQ    = 6'b000100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_KILL  = 3'd4
    } fetch_state_e;

    // Pseudo-direct jump target formed from the jump's own PC+4 region.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds the instruction, its PC+4 and a valid bit.
// Clear (bubble) takes precedence over the enable so a flush lands even when stalled.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc_plus4,
    input  logic        in_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus4,
    output logic        out_valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (clr) begin
            instr_d    = BUBBLE_INSTR;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (en) begin
            instr_d    = in_instr;
            pc_plus4_d = in_pc_plus4;
            valid_d    = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= BUBBLE_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign out_instr    = instr_q;
    assign out_pc_plus4 = pc_plus4_q;
    assign out_valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PCF, fetches over a req/rdy instruction-memory port and feeds IF/ID,
// applying hazard stalls/flushes and branch/jump redirects (no delay slot).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         PCSrcD,
    input  logic [31:0]  PCBranchD,
    input  logic         JumpD,
    output logic         IMemReq,
    output logic [31:0]  IMemAddr,
    input  logic         IMemRdy,
    input  logic [31:0]  IMemData,
    output logic [31:0]  InstrD,
    output logic [31:0]  PCPlus4D,
    output logic         ValidD,
    output fetch_state_e dbg_state
);

    // Memory handshake: IMemReq high means IMemAddr is presented and must stay
    // stable; a word transfers on any rising edge where IMemReq && IMemRdy.

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_buf_q, instr_buf_d;
    logic [31:0]  redir_pc_q, redir_pc_d;

    logic         redirect;
    logic [31:0]  redir_target;
    logic [31:0]  pc_plus4;
    logic         imem_req;
    logic         got_word;
    logic [31:0]  ifid_instr, ifid_pc_plus4;
    logic         ifid_valid;

    assign redirect     = (JumpD | PCSrcD) & ValidD & ~StallD;
    assign redir_target = JumpD ? jump_target(PCPlus4D, InstrD)
                                : (PCBranchD & ~32'd3);
    assign pc_plus4     = pc_q + 32'd4;

    always_comb begin
        imem_req = 1'b0;
        unique case (state_q)
            S_FETCH:        imem_req = ~StallF;
            S_WAIT, S_KILL: imem_req = 1'b1;
            default:        imem_req = 1'b0;
        endcase
    end

    assign got_word = imem_req & IMemRdy;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_buf_d   = instr_buf_q;
        redir_pc_d    = redir_pc_q;
        ifid_instr    = NOP_INSTR;
        ifid_pc_plus4 = '0;
        ifid_valid    = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH, S_WAIT: begin
                if (redirect) begin
                    // An issued request cannot be withdrawn; drain it in S_KILL.
                    if (imem_req && !IMemRdy) begin
                        redir_pc_d = redir_target;
                        state_d    = S_KILL;
                    end else begin
                        pc_d    = redir_target;
                        state_d = S_FETCH;
                    end
                end else if (got_word) begin
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                    if (StallD) begin
                        instr_buf_d = IMemData;
                        state_d     = S_HOLD;
                    end else begin
                        ifid_instr    = IMemData;
                        ifid_pc_plus4 = pc_plus4;
                        ifid_valid    = 1'b1;
                    end
                end else if (imem_req) begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                // PCF already points past the buffered word, so it is its PC+4.
                if (redirect) begin
                    pc_d    = redir_target;
                    state_d = S_FETCH;
                end else if (!StallD) begin
                    ifid_instr    = instr_buf_q;
                    ifid_pc_plus4 = pc_q;
                    ifid_valid    = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_KILL: begin
                if (redirect) redir_pc_d = redir_target;
                if (got_word) begin
                    pc_d    = redirect ? redir_target : redir_pc_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_buf_q <= NOP_INSTR;
            redir_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_buf_q <= instr_buf_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    fetch_stage_if_id_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk          (CLK),
        .rst          (RST),
        .en           (~StallD),
        .clr          (FlushD | redirect),
        .in_instr     (ifid_instr),
        .in_pc_plus4  (ifid_pc_plus4),
        .in_valid     (ifid_valid),
        .out_instr    (InstrD),
        .out_pc_plus4 (PCPlus4D),
        .out_valid    (ValidD)
    );

    assign IMemReq   = imem_req;
    assign IMemAddr  = pc_q;
    assign dbg_state = state_q;

    a_stall_order: assert property (@(posedge CLK) disable iff (RST) !(StallD && !StallF));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios push the expected decode-stage stream;
// a negedge monitor compares every consumed IF/ID entry against the queue.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic         PCSrcD = 1'b0, JumpD = 1'b0;
  logic [31:0]  PCBranchD = '0;
  logic         IMemReq;
  logic [31:0]  IMemAddr;
  logic         IMemRdy = 1'b0;
  logic [31:0]  IMemData = 32'hDEAD_BEEF;
  logic [31:0]  InstrD, PCPlus4D;
  logic         ValidD;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  bit cu_branch_en = 0, cu_jump_en = 0, cu_both = 0;
  logic [31:0] slow_addr = 32'h10;
  int slow_lat = 0;
  int lat_cnt  = 0;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .CLK(CLK), .RST(RST), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdy(IMemRdy), .IMemData(IMemData),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required clean end");
    $fatal(1);
  end

  // ---------------- memory image and responder ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h08:  return 32'h1000_000D;           // beq
      32'h0C:  return 32'h0800_0010;           // j 0x40
      default: return {6'b001001, a[25:0]};    // addiu filler tagged by address
    endcase
  endfunction

  always @(negedge CLK) begin
    if (IMemReq) begin
      if (lat_cnt >= ((IMemAddr == slow_addr) ? slow_lat : 0)) begin
        IMemRdy  = 1'b1;
        IMemData = mem_word(IMemAddr);
        lat_cnt  = 0;
      end else begin
        IMemRdy  = 1'b0;
        IMemData = 32'hDEAD_BEEF;
        lat_cnt++;
      end
    end else begin
      IMemRdy  = 1'b0;
      IMemData = 32'hDEAD_BEEF;
      lat_cnt  = 0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (!RST && ValidD === 1'b1 && !StallD) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got instr=%h pc4=%h, required no further instruction", InstrD, PCPlus4D);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({InstrD, PCPlus4D} !== e) begin
          n_fail++;
          $display("FAIL sb_stream: got instr=%h pc4=%h, required instr=%h pc4=%h",
                   InstrD, PCPlus4D, e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back({mem_word(a), a + 32'd4});
  endtask

  task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [32:0] a = {1'b0, lo}; a <= {1'b0, hi}; a += 33'd4) push(a[31:0]);
  endtask

  // Advance one edge, then play the decode-stage CU from the new IF/ID contents.
  task automatic cycle();
    @(posedge CLK);
    #1;
    JumpD  = cu_jump_en && ValidD && (InstrD[31:26] == OP_J);
    PCSrcD = (cu_branch_en && ValidD && (InstrD[31:26] == OP_BEQ)) ||
             (cu_both && ValidD && (InstrD[31:26] == OP_J));
  endtask

  task automatic reset_dut();
    RST = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    cu_branch_en = 0; cu_jump_en = 0; cu_both = 0;
    repeat (2) cycle();
    RST = 1'b0;
  endtask

  task automatic drain(input string name);
    @(negedge CLK);
    #1;
    check32(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // Zero-wait stream straight out of reset
    slow_lat = 0;
    reset_dut();
    check32("rst_instr", InstrD, 32'h0);
    check32("rst_pc4", PCPlus4D, 32'h0);
    check32("rst_valid", ValidD, 1'b0);
    check32("rst_req", IMemReq, 1'b0);
    check32("rst_addr", IMemAddr, 32'h0);
    check32("rst_state", dbg_state, S_IDLE);
    push_range(32'h00, 32'h10);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (k == 1) begin
        check32("e1_valid", ValidD, 1'b0);
        check32("e1_state", dbg_state, S_FETCH);
        check32("e1_req", IMemReq, 1'b1);
        check32("e1_addr", IMemAddr, 32'h0);
      end
      if (k == 2) begin
        check32("e2_valid", ValidD, 1'b1);
        check32("e2_instr", InstrD, mem_word(32'h0));
      end
    end
    drain("drain_zero_wait");

    // Three wait cycles on the word at 0x10
    slow_lat = 3;
    reset_dut();
    push_range(32'h00, 32'h14);
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k >= 5 && k <= 8) begin
        check32("wait_addr", IMemAddr, 32'h10);
        check32("wait_req", IMemReq, 1'b1);
      end
      if (k >= 6 && k <= 8) check32("wait_bubble", ValidD, 1'b0);
      if (k == 9) check32("wait_pc4", PCPlus4D, 32'h14);
    end
    drain("drain_wait");

    // Two-cycle StallF/StallD at PCF=0x20
    slow_lat = 0;
    reset_dut();
    push_range(32'h00, 32'h24);
    for (int k = 1; k <= 13; k++) begin
      cycle();
      if (k == 10 || k == 11) begin
        check32("stall_addr", IMemAddr, 32'h20);
        check32("stall_instr", InstrD, mem_word(32'h1C));
        check32("stall_req", IMemReq, 1'b0);
      end
      StallF = (k == 9 || k == 10);
      StallD = (k == 9 || k == 10);
    end
    drain("drain_stall");

    // Taken BEQ at 0x08 to 0x40
    reset_dut();
    cu_branch_en = 1; PCBranchD = 32'h40;
    push_range(32'h00, 32'h08);
    push_range(32'h40, 32'h44);
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (k == 5) begin
        check32("beq_valid", ValidD, 1'b0);
        check32("beq_bubble", InstrD, 32'h0);
        check32("beq_addr", IMemAddr, 32'h40);
      end
    end
    drain("drain_beq");

    // J at 0x0C with a concurrent taken branch to 0x80: jump target wins
    reset_dut();
    cu_jump_en = 1; cu_both = 1; PCBranchD = 32'h80;
    push_range(32'h00, 32'h0C);
    push_range(32'h40, 32'h44);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 6) begin
        check32("jmp_addr", IMemAddr, 32'h40);
        check32("jmp_valid", ValidD, 1'b0);
      end
    end
    drain("drain_jump");

    // Jump while the 0x10 fetch is outstanding: late word discarded
    slow_lat = 3;
    reset_dut();
    cu_jump_en = 1;
    push_range(32'h00, 32'h0C);
    push_range(32'h40, 32'h44);
    for (int k = 1; k <= 11; k++) begin
      cycle();
      if (k == 6) begin
        check32("kill_state", dbg_state, S_KILL);
        check32("kill_req", IMemReq, 1'b1);
      end
      if (k == 8) check32("kill_addr_held", IMemAddr, 32'h10);
      if (k == 9) begin
        check32("kill_target", IMemAddr, 32'h40);
        check32("kill_valid", ValidD, 1'b0);
      end
    end
    drain("drain_kill");

    // Branch to 0xFFFF_FFFC: PC wraps to 0
    slow_lat = 0;
    reset_dut();
    cu_branch_en = 1; PCBranchD = 32'hFFFF_FFFC;
    push_range(32'h00, 32'h08);
    push(32'hFFFF_FFFC);
    push_range(32'h00, 32'h04);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 5) check32("wrap_addr_top", IMemAddr, 32'hFFFF_FFFC);
      if (k == 6) begin
        check32("wrap_pc4", PCPlus4D, 32'h0);
        check32("wrap_addr", IMemAddr, 32'h0);
      end
    end
    drain("drain_wrap");

    // Word returns during StallD: buffered in S_HOLD, survives FlushD, then delivered
    slow_lat = 3;
    reset_dut();
    push_range(32'h00, 32'h18);
    for (int k = 1; k <= 13; k++) begin
      cycle();
      if (k == 9) begin
        check32("hold_state", dbg_state, S_HOLD);
        check32("hold_req", IMemReq, 1'b0);
        check32("hold_addr", IMemAddr, 32'h14);
      end
      if (k == 11) check32("hold_release", InstrD, mem_word(32'h10));
      StallF = (k >= 6 && k <= 9);
      StallD = (k >= 6 && k <= 9);
      FlushD = (k == 9);
    end
    drain("drain_hold");

    // Reset while waiting on 0x10: restart from RESET_PC, response ignored
    slow_lat = 3;
    reset_dut();
    push_range(32'h00, 32'h0C);
    push(32'h00);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (k == 6) check32("rstw_state", dbg_state, S_WAIT);
    end
    RST = 1'b1;
    cycle();
    check32("rstw_req", IMemReq, 1'b0);
    check32("rstw_addr", IMemAddr, 32'h0);
    check32("rstw_valid", ValidD, 1'b0);
    RST = 1'b0;
    cycle();
    cycle();
    drain("drain_rst_wait");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
